// File: rtl/pipelined_barrel_shifter_n_by_var.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter_n_by_var
// Description : Pipelined variable-amount shifter with valid/ready flow control.
//               Performs LSL / LSR / ASR / ROR on an N-bit operand with one
//               register stage per shift-amount bit; a user tag rides along.
//               Optional feature macro: PIPELINED_BARREL_SHIFTER_ROTATE_EN
//               (defined: op 3 rotates right; undefined: op 3 acts as LSR).
// Ports       : clk, rst (sync, active-high)
//               arg_vld/arg_rdy, arg_a[N], arg_shamt[SW], arg_op[2], arg_tag
//               res_vld/res_rdy, res[N], res_tag
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter_n_by_var #(
    parameter  int N     = 8,
    parameter  int TAG_W = 4,
    localparam int SW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_vld,
    output logic             arg_rdy,
    input  logic [N-1:0]     arg_a,
    input  logic [SW-1:0]    arg_shamt,
    input  logic [1:0]       arg_op,
    input  logic [TAG_W-1:0] arg_tag,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [N-1:0]     res,
    output logic [TAG_W-1:0] res_tag
);

    localparam logic [1:0]   c_op_lsl = 2'd0;
    localparam logic [1:0]   c_op_asr = 2'd2;
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
    localparam logic [1:0]   c_op_ror = 2'd3;
`endif
    localparam logic [N-1:0] c_ones   = '1;

    // Stage registers
    logic             r_vld   [SW];
    logic [N-1:0]     r_data  [SW];
    logic [SW-1:0]    r_shamt [SW];
    logic [1:0]       r_op    [SW];
    logic [TAG_W-1:0] r_tag   [SW];
    logic             r_sign  [SW];

    // Per-stage inputs (from the ports for stage 0, from the previous stage otherwise)
    logic             w_vin   [SW];
    logic [N-1:0]     w_din   [SW];
    logic [SW-1:0]    w_shin  [SW];
    logic [1:0]       w_oin   [SW];
    logic [TAG_W-1:0] w_tin   [SW];
    logic             w_sin   [SW];
    logic [N-1:0]     w_dout  [SW];

    logic             w_en;

    // The whole pipe moves in lockstep; it only freezes when a result is
    // waiting and downstream refuses it.
    assign w_en    = ~r_vld[SW-1] | res_rdy;
    assign arg_rdy = w_en;

    always_comb begin
        w_vin[0]  = arg_vld;
        w_din[0]  = arg_a;
        w_shin[0] = arg_shamt;
        w_oin[0]  = arg_op;
        w_tin[0]  = arg_tag;
        // ASR fill comes from the operand's original MSB, captured once here.
        w_sin[0]  = arg_a[N-1];
        for (int k = 1; k < SW; k++) begin
            w_vin[k]  = r_vld[k-1];
            w_din[k]  = r_data[k-1];
            w_shin[k] = r_shamt[k-1];
            w_oin[k]  = r_op[k-1];
            w_tin[k]  = r_tag[k-1];
            w_sin[k]  = r_sign[k-1];
        end
    end

    // Stage k shifts by 2^k when its shift-amount bit is set.
    always_comb begin
        for (int k = 0; k < SW; k++) begin
            w_dout[k] = w_din[k];
            if (w_shin[k][k]) begin
                case (w_oin[k])
                    c_op_lsl: w_dout[k] = w_din[k] << (1 << k);
                    c_op_asr: w_dout[k] = (w_din[k] >> (1 << k))
                                        | (w_sin[k] ? ~(c_ones >> (1 << k)) : '0);
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
                    c_op_ror: w_dout[k] = (w_din[k] >> (1 << k))
                                        | (w_din[k] << (N - (1 << k)));
`endif
                    // LSR, and op 3 when rotation is not built
                    default:  w_dout[k] = w_din[k] >> (1 << k);
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SW; k++) begin
                r_vld[k]   <= 1'b0;
                r_data[k]  <= '0;
                r_shamt[k] <= '0;
                r_op[k]    <= '0;
                r_tag[k]   <= '0;
                r_sign[k]  <= 1'b0;
            end
        end else if (w_en) begin
            for (int k = 0; k < SW; k++) begin
                r_vld[k]   <= w_vin[k];
                r_data[k]  <= w_dout[k];
                r_shamt[k] <= w_shin[k];
                r_op[k]    <= w_oin[k];
                r_tag[k]   <= w_tin[k];
                r_sign[k]  <= w_sin[k];
            end
        end
    end

    assign res_vld = r_vld[SW-1];
    assign res     = r_data[SW-1];
    assign res_tag = r_tag[SW-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter_n_by_var.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_barrel_shifter_n_by_var
// Description : Self-checking bench for pipelined_barrel_shifter_n_by_var
//               (N=8, TAG_W=4). A lockstep delay-line model of depth 3 holds
//               expected results computed with plain shift arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter_n_by_var;

    localparam int N     = 8;
    localparam int TAG_W = 4;
    localparam int SW    = 3;
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
    localparam logic [7:0] C_OP3_B5 = 8'hB6;
`else
    localparam logic [7:0] C_OP3_B5 = 8'h16;
`endif

    logic             clk;
    logic             rst;
    logic             arg_vld;
    logic             arg_rdy;
    logic [N-1:0]     arg_a;
    logic [SW-1:0]    arg_shamt;
    logic [1:0]       arg_op;
    logic [TAG_W-1:0] arg_tag;
    logic             res_vld;
    logic             res_rdy;
    logic [N-1:0]     res;
    logic [TAG_W-1:0] res_tag;

    pipelined_barrel_shifter_n_by_var #(.N(N), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .arg_vld   (arg_vld),
        .arg_rdy   (arg_rdy),
        .arg_a     (arg_a),
        .arg_shamt (arg_shamt),
        .arg_op    (arg_op),
        .arg_tag   (arg_tag),
        .res_vld   (res_vld),
        .res_rdy   (res_rdy),
        .res       (res),
        .res_tag   (res_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: three lockstep slots, slot 2 is what the output shows.
    logic       m_v [3];
    logic [7:0] m_d [3];
    logic [3:0] m_t [3];
    logic       m_rst   = 1'b0;
    logic       started = 1'b0;
    logic       last_acc;

    logic [7:0] a_r;
    logic [2:0] s_r;
    logic [1:0] o_r;
    logic [3:0] t_r;
    int         acc;

    function automatic logic [7:0] ref_shift(input logic [7:0] a, input logic [2:0] s,
                                             input logic [1:0] o);
        logic [15:0] dbl;
        case (o)
            2'd0: return a << s;
            2'd1: return a >> s;
            2'd2: return 8'($signed(a) >>> s);
            default: begin
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
                dbl = {a, a} >> s;
                return dbl[7:0];
`else
                dbl = {8'h00, a} >> s;
                return dbl[7:0];
`endif
            end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", nm, obs, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs against the model, then
    // advance the model the way the pipe should advance on the coming edge.
    task automatic tick(input logic r, input logic v, input logic [7:0] a,
                        input logic [2:0] s, input logic [1:0] o, input logic [3:0] t,
                        input logic rr, input logic [7:0] ex);
        logic en;
        rst       = r;
        arg_vld   = v;
        arg_a     = a;
        arg_shamt = s;
        arg_op    = o;
        arg_tag   = t;
        res_rdy   = rr;
        #1;
        en = !m_v[2] || rr;
        if (started) begin
            chk("arg_rdy", 8'(arg_rdy), 8'(en));
            chk("res_vld", 8'(res_vld), 8'(m_v[2]));
            if (m_v[2] || m_rst) begin
                chk("res", res, m_d[2]);
                chk("res_tag", 8'(res_tag), 8'(m_t[2]));
            end
        end
        last_acc = !r && v && en;
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                m_v[i] = 1'b0;
                m_d[i] = 8'h00;
                m_t[i] = 4'h0;
            end
            m_rst = 1'b1;
        end else begin
            m_rst = 1'b0;
            if (en) begin
                m_v[2] = m_v[1]; m_d[2] = m_d[1]; m_t[2] = m_t[1];
                m_v[1] = m_v[0]; m_d[1] = m_d[0]; m_t[1] = m_t[0];
                m_v[0] = v;      m_d[0] = ex;     m_t[0] = t;
            end
        end
        started = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_rand(input logic v, input logic rr);
        a_r = 8'($urandom);
        s_r = 3'($urandom);
        o_r = 2'($urandom);
        t_r = 4'($urandom);
        tick(1'b0, v, a_r, s_r, o_r, t_r, rr, ref_shift(a_r, s_r, o_r));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = 8'h00;
            m_t[i] = 4'h0;
        end

        // 1. reset with arg_vld high: nothing may emerge
        tick(1'b1, 1'b1, 8'h5A, 3'd1, 2'd0, 4'h7, 1'b1, 8'hB4);
        tick(1'b1, 1'b1, 8'h5A, 3'd1, 2'd0, 4'h7, 1'b1, 8'hB4);
        for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 8'h00, 3'd0, 2'd0, 4'h0, 1'b1, 8'h00);

        // 2. directed 0xB5 >> 3 in all four modes, back to back
        tick(1'b0, 1'b1, 8'hB5, 3'd3, 2'd0, 4'h1, 1'b1, 8'hA8);
        tick(1'b0, 1'b1, 8'hB5, 3'd3, 2'd1, 4'h2, 1'b1, 8'h16);
        tick(1'b0, 1'b1, 8'hB5, 3'd3, 2'd2, 4'h3, 1'b1, 8'hF6);
        tick(1'b0, 1'b1, 8'hB5, 3'd3, 2'd3, 4'h4, 1'b1, C_OP3_B5);
        for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 8'h00, 3'd0, 2'd0, 4'h0, 1'b1, 8'h00);

        // 3. full sweep of op x shamt with random operands, plus ASR corner
        for (int o = 0; o < 4; o++) begin
            for (int s = 0; s < 8; s++) begin
                a_r = 8'($urandom);
                t_r = 4'($urandom);
                tick(1'b0, 1'b1, a_r, 3'(s), 2'(o), t_r, 1'b1, ref_shift(a_r, 3'(s), 2'(o)));
            end
        end
        tick(1'b0, 1'b1, 8'h80, 3'd7, 2'd2, 4'hE, 1'b1, 8'hFF);
        for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 8'h00, 3'd0, 2'd0, 4'h0, 1'b1, 8'h00);

        // 4. backpressure: 6 transactions, res_rdy low for 4 cycles mid-stream
        acc = 0;
        for (int c = 0; c < 16; c++) begin
            a_r = 8'($urandom);
            s_r = 3'($urandom);
            o_r = 2'($urandom);
            tick(1'b0, acc < 6, a_r, s_r, o_r, 4'(acc + 8), !(c >= 3 && c <= 6),
                 ref_shift(a_r, s_r, o_r));
            if (last_acc) acc++;
        end
        chk("accepted_count", 8'(acc), 8'd6);

        // 5. alternating bubbles
        for (int c = 0; c < 10; c++) tick_rand(c % 2 == 0, 1'b1);
        for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 8'h00, 3'd0, 2'd0, 4'h0, 1'b1, 8'h00);

        // random valid/ready mix
        for (int c = 0; c < 60; c++) tick_rand(1'($urandom), 1'($urandom));
        for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 8'h00, 3'd0, 2'd0, 4'h0, 1'b1, 8'h00);

        // 6. reset mid-flight flushes both accepted transactions
        tick_rand(1'b1, 1'b1);
        tick_rand(1'b1, 1'b1);
        tick(1'b1, 1'b0, 8'h00, 3'd0, 2'd0, 4'h0, 1'b1, 8'h00);
        for (int c = 0; c < 5; c++) tick(1'b0, 1'b0, 8'h00, 3'd0, 2'd0, 4'h0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_barrel_shifter_n_by_var.md
# pipelined_barrel_shifter_n_by_var

Parametrised, pipelined, variable-amount shifter: the successor to the fixed-shift combinational modules, generalised to run-time shift amount and mode. It performs logical left, logical right, arithmetic right or rotate right on an N-bit operand, with one register stage per shift-amount bit. It sits in the arithmetic/pipelining exercises as a throughput-one datapath block with valid/ready flow control and a pass-through tag.

## Interface

- `N`, default 8: operand width. It must be a power of two and ≥ 4.
- `TAG_W`, default 4: width of the opaque tag carried alongside the operand.
- `SW`, derived as `$clog2(N)`, not overridable: shift-amount width; it also equals the pipeline depth.

Ports:

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `arg_vld`  in  1  input operand valid.
- `arg_rdy`  out  1  block can accept an input this cycle.
- `arg_a`  in  N  operand, unsigned bit vector.
- `arg_shamt`  in  SW  shift amount, 0..N-1.
- `arg_op`  in  2  mode: 0 LSL, 1 LSR, 2 ASR, 3 ROR.
- `arg_tag`  in  TAG_W  user tag, returned unchanged.
- `res_vld`  out  1  result valid.
- `res_rdy`  in  1  downstream accepts the result.
- `res`  out  N  shifted result.
- `res_tag`  out  TAG_W  tag of the transaction in `res`.

## Operation

- The pipeline has SW stages. Stage k (k = 0..SW-1) shifts by 2^k when `shamt[k]` is 1, otherwise it passes the data through.
- Each stage registers: valid, data, remaining shamt bits, op and tag.
- Fill value for LSL and LSR is 0.
- Fill value for ASR is the original MSB of `arg_a`. It is captured at input and carried down the pipe; it is not re-read from intermediate data.
- For ROR, the bits shifted out at the LSB end re-enter at the MSB end.
- Shift amount 0 in every mode gives `res = arg_a`.
- Global advance enable: `en = ~res_vld | res_rdy`.
- `arg_rdy = en`.
- All stages advance together when `en` is 1 and hold when it is 0. Bubbles are not collapsed.
- A transfer happens on a cycle where `arg_vld & arg_rdy`. When `arg_vld = 0` with `en = 1`, a bubble (valid = 0) enters stage 0.
- `res`, `res_tag` and `res_vld` come directly from the last stage's registers; there is no combinational path from `arg_*` to `res*`.
- `arg_rdy` depends combinationally on `res_rdy` (documented ready path).
- Order is strictly preserved; there is no reordering or dropping.

## Timing

- Reset: every stage valid bit is 0, `res_vld = 0`, `res = 0`, `res_tag = 0`, and `arg_rdy = 1` one cycle after reset.
- Latency: an input accepted on edge t appears with `res_vld = 1` after edge t+SW-1 (SW register stages). For N = 8 this is 3 cycles.
- Throughput: one result per cycle while `res_rdy` is held at 1.
- Stall: while `res_vld & ~res_rdy`, every stage holds, `arg_rdy = 0`, and `res`/`res_tag` stay stable.
- Release: the cycle `res_rdy` rises, the pipe advances and `arg_rdy` is 1 in that same cycle.
- Simultaneous accept and emit on one edge is permitted and is the normal streaming case.
- Reset asserted mid-operation flushes all in-flight transactions the next edge. No result is emitted for them.
- `arg_a`, `arg_shamt`, `arg_op` and `arg_tag` are ignored when `arg_vld = 0`.

## Configuration

- Macro: `PIPELINED_BARREL_SHIFTER_ROTATE_EN`.
- Defined: op 3 performs ROR as described above.
- Undefined: rotate wiring is not built, and op 3 behaves exactly as op 1 (LSR, zero fill). Ops 0–2 are unchanged. Latency, handshake and reset behaviour are identical in both builds.

## Test plan

1. Reset, N=8: hold `rst` 2 cycles -> `res_vld = 0`, `res = 8'h00`, `arg_rdy = 1`. Raise `arg_vld` during reset -> nothing emerges.
2. N=8, `arg_a = 8'hB5`, shamt 3, ops 0/1/2/3 on consecutive cycles with tags 1..4, `res_rdy = 1` -> results `8'hA8`, `8'h16`, `8'hF6`, `8'hB6` with tags 1..4 on 4 consecutive cycles, the first 3 cycles after the first accept. Without the macro, the 4th result is `8'h16`.
3. Sweep: every op, every shamt 0..7, random `arg_a`, compared against a reference model. Shamt 0 returns `arg_a` for all ops. ASR of `8'h80` by 7 gives `8'hFF`.
4. Backpressure: stream 6 transactions and drop `res_rdy` for 4 cycles mid-stream -> `res`/`res_tag` stable and `arg_rdy = 0` while stalled. All 6 results arrive in order with no loss or duplication.
5. Bubbles: alternate `arg_vld` 1/0 -> `res_vld` shows the same alternating pattern delayed by 3 cycles.
6. Reset mid-flight: accept 2 transactions, then assert `rst` one cycle later -> neither is emitted, and the pipe is empty with `arg_rdy = 1` after reset.
